// File: rtl/instr_mem_sync.sv
// Purpose: writable instruction memory with a registered fetch port, a program-load port and a post-reset NOP fill.
// Latency: a fetch presented in cycle N shows up on Instr in cycle N+1; a write lands at the edge it is sampled on.
// Backpressure: stall freezes Instr/instr_valid/fault. Fetch and write are refused until the fill finishes (ready=1).
module instr_mem_sync #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 64,
    parameter logic [DATA_W-1:0] INIT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PC,
    input  logic              fetch_en,
    input  logic              stall,
    output logic [DATA_W-1:0] Instr,
    output logic              instr_valid,
    output logic              fault,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     clr_idx;
    logic              clearing;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              fetch_ok;
    logic              wr_ok;
    logic [AW-1:0]     fetch_idx;
    logic [AW-1:0]     wr_idx;

    // Word aligned, and every PC bit above the index field is zero (no aliasing).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == '0);
    endfunction

    assign fetch_ok  = addr_ok(PC);
    assign wr_ok     = addr_ok(wr_addr);
    assign fetch_idx = PC[AW+1:2];
    assign wr_idx    = wr_addr[AW+1:2];

    // State register: reset always restarts the fill sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR once the last word has been filled.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_idx == AW'(DEPTH - 1)) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // State decode: ready follows the register, so it rises the cycle after the last fill write.
    always_comb begin
        clearing = (state == CLEAR);
        ready    = (state == RUN);
    end

    // Fill pointer: walks every word once per reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
        end else if (clearing) begin
            clr_idx <= clr_idx + AW'(1);
        end
    end

    // Memory array: the fill owns the write port during CLEAR, the load port owns it during RUN; no write while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clr_idx] <= INIT_WORD;
            end else if (wr_en && wr_ok) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    // Fetch register: the array is read with its pre-edge contents, so a same-word write is read-first.
    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            Instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else if (!stall) begin
            if (!fetch_en) begin
                Instr       <= '0;
                instr_valid <= 1'b0;
                fault       <= 1'b0;
            end else if (fetch_ok) begin
                Instr       <= mem[fetch_idx];
                instr_valid <= 1'b1;
                fault       <= 1'b0;
            end else begin
                Instr       <= '0;
                instr_valid <= 1'b1;
                fault       <= 1'b1;
            end
        end
    end

    // Write error flag: one-cycle registered pulse for a refused write (during fill or to a bad address).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (clearing || !wr_ok);
        end
    end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync at DEPTH=16: directed program-load sequences plus random traffic.
// Every clock is compared against a cycle model built from word-indexed arrays and a fill countdown.
// Outputs are sampled 1 time unit after each rising edge; inputs change right after sampling.
module tb_instr_mem_sync;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] PC;
    logic              fetch_en;
    logic              stall;
    logic [DATA_W-1:0] Instr;
    logic              instr_valid;
    logic              fault;
    logic              ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;

    instr_mem_sync #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_WORD (32'h00000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PC          (PC),
        .fetch_en    (fetch_en),
        .stall       (stall),
        .Instr       (Instr),
        .instr_valid (instr_valid),
        .fault       (fault),
        .ready       (ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_err      (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    int          clear_left;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_fault;
    logic        e_ready;
    logic        e_wr_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < DEPTH);
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            clear_left = DEPTH;
            e_instr    = '0;
            e_valid    = 1'b0;
            e_fault    = 1'b0;
            e_wr_err   = 1'b0;
        end else if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = 32'h0;
            clear_left--;
            e_instr  = '0;
            e_valid  = 1'b0;
            e_fault  = 1'b0;
            e_wr_err = wr_en;
        end else begin
            if (!stall) begin
                if (!fetch_en) begin
                    e_instr = '0; e_valid = 1'b0; e_fault = 1'b0;
                end else if (legal(PC)) begin
                    e_instr = mem_m[PC / 4]; e_valid = 1'b1; e_fault = 1'b0;
                end else begin
                    e_instr = '0; e_valid = 1'b1; e_fault = 1'b1;
                end
            end
            if (wr_en && legal(wr_addr)) mem_m[wr_addr / 4] = wr_data;
            e_wr_err = wr_en && !legal(wr_addr);
        end
        e_ready = (clear_left == 0);
        #1;
        chk("instr", Instr, e_instr);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
        chk("fault", {31'b0, fault}, {31'b0, e_fault});
        chk("ready", {31'b0, ready}, {31'b0, e_ready});
        chk("wr_err", {31'b0, wr_err}, {31'b0, e_wr_err});
    endtask

    task automatic idle_inputs();
        rst = 1'b0; fetch_en = 1'b0; stall = 1'b0; wr_en = 1'b0;
        PC = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic fetch(input logic [31:0] a);
        idle_inputs();
        fetch_en = 1'b1; PC = a;
        step();
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d);
        idle_inputs();
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return $urandom;
            1:       return {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
            2:       return 32'(DEPTH * 4) + 32'($urandom_range(0, 64) * 4);
            default: return {$urandom_range(0, DEPTH - 1), 2'b00};
        endcase
    endfunction

    // Release reset and count fill cycles with random traffic that must all be ignored.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            idle_inputs();
            fetch_en = 1'($urandom);
            stall    = 1'($urandom);
            wr_en    = 1'($urandom);
            PC       = rand_addr();
            wr_addr  = {$urandom_range(0, DEPTH - 1), 2'b00};
            wr_data  = $urandom;
            step();
            chk({tag, "_instr_during_clear"}, {Instr[31:1], instr_valid}, 32'h0);
            n++;
        end while (ready !== 1'b1 && n < 40);
        chk({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clear_left = DEPTH;
        e_instr = '0; e_valid = 1'b0; e_fault = 1'b0; e_ready = 1'b0; e_wr_err = 1'b0;

        // Reset for two cycles, then the fill sequence
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        wait_ready("reset");
        fetch(32'h3C);
        chk("cleared_3c", Instr, 32'h0);

        // Program load and fetch
        write(32'h00, 32'h00221820);
        write(32'h14, 32'h34220007);
        write(32'h3C, 32'h0800000F);
        fetch(32'h14);
        chk("load_14", Instr, 32'h34220007);
        chk("load_14_valid", {31'b0, instr_valid}, 32'h1);
        fetch(32'h3C);
        chk("load_3c", Instr, 32'h0800000F);

        // Stall holds the previous fetch while PC moves
        fetch(32'h00);
        chk("stall_pre", Instr, 32'h00221820);
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            stall = 1'b1; fetch_en = 1'b1; PC = 32'h14;
            step();
            chk("stall_hold", Instr, 32'h00221820);
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
        end
        fetch(32'h14);
        chk("stall_release", Instr, 32'h34220007);

        // Faults: misaligned, out of range, rejected write
        fetch(32'h16);
        chk("fault_misalign", {Instr[30:0], fault}, 32'h1);
        fetch(32'h40);
        chk("fault_range", {31'b0, fault}, 32'h1);
        write(32'h40, 32'h12345678);
        chk("wr_err_pulse", {31'b0, wr_err}, 32'h1);
        fetch(32'h00);
        chk("wr_err_clears", {31'b0, wr_err}, 32'h0);
        chk("no_alias_write", Instr, 32'h00221820);

        // Read-first collision
        idle_inputs();
        fetch_en = 1'b1; PC = 32'h14;
        wr_en = 1'b1; wr_addr = 32'h14; wr_data = 32'hDEADBEEF;
        step();
        chk("collide_old", Instr, 32'h34220007);
        fetch(32'h14);
        chk("collide_new", Instr, 32'hDEADBEEF);

        // Reset during RUN with a valid output, then fill again
        idle_inputs();
        rst = 1'b1;
        step();
        chk("midrst_instr", Instr, 32'h0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
        wait_ready("midrst");
        fetch(32'h00);
        chk("midrst_mem00", Instr, 32'h0);
        fetch(32'h14);
        chk("midrst_mem14", Instr, 32'h0);
        idle_inputs();
        step();
        chk("gate_valid", {31'b0, instr_valid}, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            rst      = ($urandom_range(0, 99) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            fetch_en = ($urandom_range(0, 4) != 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            PC       = rand_addr();
            wr_addr  = rand_addr();
            wr_data  = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
